// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Initiator side of the CSR register-file port, sitting at commit. Takes one
//   committing instruction at a time. It sequences a csrrd/csrwr/csrxchg access,
//   an exception entry or an ertn return onto the CSR port. It then returns the
//   old CSR value to writeback and/or issues a one-cycle flush with the
//   redirect PC.
//
// Ports
//   clk, rstn                 clock, async active-low reset
//   in_valid/in_ready         commit request handshake (ready only in IDLE)
//   in_op, in_csr_num, in_rj, in_rd, in_pc, in_ex, in_ecode, in_esubcode,
//   in_vaddr                  request fields, latched on acceptance
//   csr_addr/re/we/wmask/wdata/rdata   CSR access port (rdata combinational)
//   ex_en, ecode, esubcode, pc, vaddr  exception / ertn signalling to the CSR file
//   new_pc, ex_entryPC        ERA and EENTRY contents from the CSR file
//   rsp_valid/rsp_ready/rsp_rdata      old-CSR-value response to writeback
//   flush, flush_pc           pipeline flush pulse and redirect target
module csr_access_unit #(
    parameter logic [5:0] ERTN_CODE = 6'h3e
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [13:0] in_csr_num,
    input  logic [31:0] in_rj,
    input  logic [31:0] in_rd,
    input  logic [31:0] in_pc,
    input  logic        in_ex,
    input  logic [5:0]  in_ecode,
    input  logic        in_esubcode,
    input  logic [31:0] in_vaddr,
    output logic [13:0] csr_addr,
    output logic        csr_re,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        ex_en,
    output logic [5:0]  ecode,
    output logic        esubcode,
    output logic [31:0] pc,
    output logic [31:0] vaddr,
    input  logic [31:0] new_pc,
    input  logic [31:0] ex_entryPC,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        flush,
    output logic [31:0] flush_pc
);

    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_XCHG = 3'd3;
    localparam logic [2:0] OP_ERTN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCESS, S_RESP, S_EXC, S_ERTN, S_FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [2:0]  op_q;
    logic [13:0] num_q;
    logic [31:0] rj_q, rd_q, pc_q, vaddr_q;
    logic [5:0]  ecode_q;
    logic        esub_q;

    logic accept;
    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; exception beats ertn beats CSR ops, anything else is a no-op
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_ex)                                 state_nxt = S_EXC;
                    else if (in_op == OP_ERTN)                 state_nxt = S_ERTN;
                    else if (in_op >= OP_RD && in_op <= OP_XCHG) state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = (op_q == OP_RD) ? S_IDLE : S_FLUSH;
            S_EXC:    state_nxt = S_FLUSH;
            S_ERTN:   state_nxt = S_FLUSH;
            S_FLUSH:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic; everything is zero outside its owning state. ecode in
    // particular must stay 0, the register file decodes the ertn code every cycle.
    always_comb begin
        in_ready  = (state == S_IDLE) && rstn;
        csr_addr  = '0;
        csr_re    = 1'b0;
        csr_we    = 1'b0;
        csr_wmask = '0;
        csr_wdata = '0;
        ex_en     = 1'b0;
        ecode     = '0;
        esubcode  = 1'b0;
        pc        = '0;
        vaddr     = '0;
        rsp_valid = 1'b0;
        flush     = 1'b0;
        case (state)
            S_ACCESS: begin
                csr_addr  = num_q;
                csr_re    = 1'b1;
                csr_we    = (op_q == OP_WR) || (op_q == OP_XCHG);
                csr_wmask = (op_q == OP_XCHG) ? rj_q :
                            (op_q == OP_WR)   ? 32'hffff_ffff : 32'h0;
                csr_wdata = rd_q;
            end
            S_RESP:  rsp_valid = 1'b1;
            S_EXC: begin
                ex_en    = 1'b1;
                ecode    = ecode_q;
                esubcode = esub_q;
                pc       = pc_q;
                vaddr    = vaddr_q;
            end
            S_ERTN:  ecode = ERTN_CODE;
            S_FLUSH: flush = 1'b1;
            default: ;
        endcase
    end

    // Request latch, response data and redirect target
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q      <= '0;
            num_q     <= '0;
            rj_q      <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            vaddr_q   <= '0;
            ecode_q   <= '0;
            esub_q    <= 1'b0;
            rsp_rdata <= '0;
            flush_pc  <= '0;
        end else begin
            if (accept) begin
                op_q    <= in_op;
                num_q   <= in_csr_num;
                rj_q    <= in_rj;
                rd_q    <= in_rd;
                pc_q    <= in_pc;
                vaddr_q <= in_vaddr;
                ecode_q <= in_ecode;
                esub_q  <= in_esubcode;
            end
            // rdata is sampled in the same cycle the write is presented, so it
            // is the pre-write value
            if (state == S_ACCESS) rsp_rdata <= csr_rdata;
            case (state)
                S_RESP:  if (rsp_ready && op_q != OP_RD) flush_pc <= pc_q + 32'd4;
                S_EXC:   flush_pc <= ex_entryPC;
                S_ERTN:  flush_pc <= new_pc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [13:0] in_csr_num;
    logic [31:0] in_rj, in_rd, in_pc, in_vaddr;
    logic        in_ex;
    logic [5:0]  in_ecode;
    logic        in_esubcode;
    logic [13:0] csr_addr;
    logic        csr_re, csr_we;
    logic [31:0] csr_wmask, csr_wdata, csr_rdata;
    logic        ex_en;
    logic [5:0]  ecode;
    logic        esubcode;
    logic [31:0] pc, vaddr, new_pc, ex_entryPC;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        flush;
    logic [31:0] flush_pc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    csr_access_unit #(.ERTN_CODE(6'h3e)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_csr_num(in_csr_num), .in_rj(in_rj), .in_rd(in_rd),
        .in_pc(in_pc), .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode),
        .in_vaddr(in_vaddr), .csr_addr(csr_addr), .csr_re(csr_re), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .ex_en(ex_en), .ecode(ecode), .esubcode(esubcode), .pc(pc), .vaddr(vaddr),
        .new_pc(new_pc), .ex_entryPC(ex_entryPC), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .flush(flush), .flush_pc(flush_pc)
    );

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        in_valid = 0; in_op = 0; in_csr_num = 0; in_rj = 0; in_rd = 0; in_pc = 0;
        in_ex = 0; in_ecode = 0; in_esubcode = 0; in_vaddr = 0;
    endtask

    task automatic test_reset();
        rstn = 0; clear_req(); csr_rdata = 0; new_pc = 0; ex_entryPC = 0; rsp_ready = 0;
        tick(); tick();
        total++; if ({in_ready, csr_addr, csr_re, csr_we, csr_wmask, csr_wdata, ex_en, ecode, esubcode, pc, vaddr, rsp_valid, rsp_rdata, flush, flush_pc} !== '0)
            $display("FAIL reset_outs: some output nonzero (in_ready=%b flush=%b rsp_valid=%b)", in_ready, flush, rsp_valid); else passed++;
        rstn = 1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passed++;
        tick();
    endtask

    task automatic test_noop();
        in_valid = 1; in_op = 3'd5; in_csr_num = 14'h12;
        tick();
        clear_req();
        total++; if ({in_ready, csr_re, rsp_valid, flush} !== 4'b1000)
            $display("FAIL noop: ready/re/rv/flush=%b want 1000", {in_ready, csr_re, rsp_valid, flush}); else passed++;
        tick();
        total++; if ({in_ready, csr_re, rsp_valid, flush} !== 4'b1000)
            $display("FAIL noop_2: ready/re/rv/flush=%b want 1000", {in_ready, csr_re, rsp_valid, flush}); else passed++;
    endtask

    task automatic test_csrrd();
        in_valid = 1; in_op = 3'd1; in_csr_num = 14'h30; in_rd = 32'h5555_5555;
        tick();
        clear_req(); in_csr_num = 14'h3ff;  // must be ignored after acceptance
        csr_rdata = 32'hDEADBEEF; #1;
        total++; if ({csr_re, csr_we, csr_addr, csr_wmask} !== {1'b1, 1'b0, 14'h30, 32'h0})
            $display("FAIL rd_access: re=%b we=%b addr=%h wmask=%h want 1 0 0030 00000000", csr_re, csr_we, csr_addr, csr_wmask); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL rd_busy: in_ready=%b want 0", in_ready); else passed++;
        tick();
        csr_rdata = 32'h0; rsp_ready = 1; #1;
        total++; if ({rsp_valid, rsp_rdata, flush, csr_re} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0})
            $display("FAIL rd_resp: valid=%b rdata=%h flush=%b re=%b want 1 deadbeef 0 0", rsp_valid, rsp_rdata, flush, csr_re); else passed++;
        tick();
        rsp_ready = 0;
        total++; if ({in_ready, rsp_valid, flush} !== 3'b100)
            $display("FAIL rd_done: ready/valid/flush=%b want 100", {in_ready, rsp_valid, flush}); else passed++;
    endtask

    task automatic test_csrxchg();
        in_valid = 1; in_op = 3'd3; in_csr_num = 14'h6; in_rj = 32'h0000FFFF;
        in_rd = 32'h12345678; in_pc = 32'h1C000100;
        tick();
        clear_req(); in_pc = 32'hFFFF_FFF0;
        csr_rdata = 32'hAAAAAAAA; #1;
        total++; if ({csr_re, csr_we, csr_addr, csr_wmask, csr_wdata} !== {1'b1, 1'b1, 14'h6, 32'h0000FFFF, 32'h12345678})
            $display("FAIL xchg_access: we=%b addr=%h wmask=%h wdata=%h want 1 0006 0000ffff 12345678", csr_we, csr_addr, csr_wmask, csr_wdata); else passed++;
        tick();
        csr_rdata = 32'h0; rsp_ready = 1; #1;
        total++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hAAAAAAAA})
            $display("FAIL xchg_resp: valid=%b rdata=%h want 1 aaaaaaaa", rsp_valid, rsp_rdata); else passed++;
        tick();
        rsp_ready = 0;
        total++; if ({flush, flush_pc, rsp_valid, in_ready} !== {1'b1, 32'h1C000104, 1'b0, 1'b0})
            $display("FAIL xchg_flush: flush=%b pc=%h valid=%b ready=%b want 1 1c000104 0 0", flush, flush_pc, rsp_valid, in_ready); else passed++;
        tick();
        total++; if ({flush, in_ready, flush_pc} !== {1'b0, 1'b1, 32'h1C000104})
            $display("FAIL xchg_after: flush=%b ready=%b pc=%h want 0 1 1c000104", flush, in_ready, flush_pc); else passed++;
    endtask

    task automatic test_exception();
        in_valid = 1; in_ex = 1; in_op = 3'd2; in_ecode = 6'h8; in_esubcode = 0;
        in_pc = 32'h1C000200; in_vaddr = 32'h5; in_csr_num = 14'h1; in_rd = 32'hFFFF;
        ex_entryPC = 32'h1C008000;
        tick();
        clear_req(); in_ecode = 6'h3f; in_pc = 32'h1;
        total++; if ({ex_en, ecode, esubcode, pc, vaddr} !== {1'b1, 6'h8, 1'b0, 32'h1C000200, 32'h5})
            $display("FAIL exc_entry: ex_en=%b ecode=%h sub=%b pc=%h vaddr=%h want 1 08 0 1c000200 00000005", ex_en, ecode, esubcode, pc, vaddr); else passed++;
        total++; if ({csr_we, csr_re, rsp_valid} !== 3'b000)
            $display("FAIL exc_nowrite: we/re/rv=%b want 000", {csr_we, csr_re, rsp_valid}); else passed++;
        tick();
        ex_entryPC = 32'h0;
        total++; if ({flush, flush_pc, ex_en, ecode, csr_we} !== {1'b1, 32'h1C008000, 1'b0, 6'h0, 1'b0})
            $display("FAIL exc_flush: flush=%b pc=%h ex_en=%b ecode=%h we=%b want 1 1c008000 0 00 0", flush, flush_pc, ex_en, ecode, csr_we); else passed++;
        tick();
        total++; if ({flush, in_ready} !== 2'b01) $display("FAIL exc_done: flush/ready=%b want 01", {flush, in_ready}); else passed++;
    endtask

    task automatic test_ertn();
        in_valid = 1; in_op = 3'd4; new_pc = 32'h1C000300;
        tick();
        clear_req();
        total++; if ({ecode, ex_en, flush} !== {6'h3e, 1'b0, 1'b0})
            $display("FAIL ertn_code: ecode=%h ex_en=%b flush=%b want 3e 0 0", ecode, ex_en, flush); else passed++;
        tick();
        new_pc = 32'h0;
        total++; if ({flush, flush_pc, ecode} !== {1'b1, 32'h1C000300, 6'h0})
            $display("FAIL ertn_flush: flush=%b pc=%h ecode=%h want 1 1c000300 00", flush, flush_pc, ecode); else passed++;
        tick();
        total++; if ({flush, ecode, in_ready} !== {1'b0, 6'h0, 1'b1})
            $display("FAIL ertn_done: flush=%b ecode=%h ready=%b want 0 00 1", flush, ecode, in_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        // csrrd stalled in RESP while a csrwr waits on in_valid
        in_valid = 1; in_op = 3'd1; in_csr_num = 14'h40;
        tick();
        in_op = 3'd2; in_csr_num = 14'h41; in_rd = 32'hCAFEF00D; in_pc = 32'hFFFFFFFC;
        csr_rdata = 32'h0BADC0DE;
        tick();
        csr_rdata = 32'h0; rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            total++; if ({rsp_valid, rsp_rdata, in_ready, csr_we} !== {1'b1, 32'h0BADC0DE, 1'b0, 1'b0})
                $display("FAIL stall_%0d: valid=%b rdata=%h ready=%b we=%b want 1 0badc0de 0 0", i, rsp_valid, rsp_rdata, in_ready, csr_we); else passed++;
            tick();
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        total++; if ({in_ready, rsp_valid, flush} !== 3'b100)
            $display("FAIL stall_release: ready/valid/flush=%b want 100", {in_ready, rsp_valid, flush}); else passed++;
        tick();  // waiting csrwr accepted here
        clear_req(); csr_rdata = 32'h11112222; #1;
        total++; if ({csr_we, csr_addr, csr_wmask, csr_wdata} !== {1'b1, 14'h41, 32'hFFFFFFFF, 32'hCAFEF00D})
            $display("FAIL wr_access: we=%b addr=%h wmask=%h wdata=%h want 1 0041 ffffffff cafef00d", csr_we, csr_addr, csr_wmask, csr_wdata); else passed++;
        tick();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        // pc+4 wraps to zero
        total++; if ({flush, flush_pc, rsp_rdata} !== {1'b1, 32'h0, 32'h11112222})
            $display("FAIL wr_flush_wrap: flush=%b pc=%h rdata=%h want 1 00000000 11112222", flush, flush_pc, rsp_rdata); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_op();
        in_valid = 1; in_op = 3'd2; in_csr_num = 14'h7; in_rd = 32'h77; in_pc = 32'h1C000400;
        tick();
        clear_req(); csr_rdata = 32'h99999999;
        tick();
        total++; if (rsp_valid !== 1'b1) $display("FAIL mid_in_resp: valid=%b want 1", rsp_valid); else passed++;
        #2 rstn = 0; #1;
        total++; if ({in_ready, csr_we, rsp_valid, rsp_rdata, flush, flush_pc, ecode} !== '0)
            $display("FAIL mid_reset_outs: ready=%b valid=%b rdata=%h flush=%b pc=%h want all 0", in_ready, rsp_valid, rsp_rdata, flush, flush_pc); else passed++;
        rsp_ready = 1;
        tick();
        rstn = 1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_release_ready: got %b want 1", in_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({flush, rsp_valid, in_ready} !== 3'b001)
                $display("FAIL mid_quiet_%0d: flush/valid/ready=%b want 001", i, {flush, rsp_valid, in_ready}); else passed++;
        end
        rsp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_noop();
        test_csrrd();
        test_csrxchg();
        test_exception();
        test_ertn();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR register-file interface. Sits at the writeback/commit stage.
- Sequences csrrd/csrwr/csrxchg accesses, exception entry and ertn return onto the CSR port, one operation at a time.
- Returns the old CSR value to writeback and issues pipeline flushes with the redirect PC.

Parameters:
ERTN_CODE, 6'h3e, ecode value presented (without ex_en) to request ertn handling; must be nonzero and not a real exception code

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
in_valid  in  1  commit request valid
in_ready  out  1  unit can accept request
in_op  in  3  0 none, 1 csrrd, 2 csrwr, 3 csrxchg, 4 ertn, others = none
in_csr_num  in  14  CSR address
in_rj  in  32  write mask (csrxchg only)
in_rd  in  32  write data
in_pc  in  32  PC of committing instruction
in_ex  in  1  instruction carries an exception
in_ecode  in  6  exception code
in_esubcode  in  1  exception subcode
in_vaddr  in  32  faulting address
csr_addr  out  14  CSR address
csr_re  out  1  CSR read enable
csr_we  out  1  CSR write enable
csr_wmask  out  32  CSR write mask
csr_wdata  out  32  CSR write data
csr_rdata  in  32  CSR read data, combinational from csr_addr
ex_en  out  1  exception entry strobe
ecode  out  6  exception / ertn code
esubcode  out  1  exception subcode
pc  out  32  exception PC
vaddr  out  32  exception bad address
new_pc  in  32  ERA contents
ex_entryPC  in  32  EENTRY contents
rsp_valid  out  1  old-CSR-value response valid
rsp_ready  in  1  writeback accepts response
rsp_rdata  out  32  old CSR value
flush  out  1  pipeline flush, one-cycle pulse
flush_pc  out  32  redirect target

Behaviour:
- States: IDLE, ACCESS, RESP, EXC, ERTN, FLUSH.
- Handshake and dispatch:
  - in_ready=1 only in IDLE.
  - Accept on in_valid&in_ready; all in_* fields are latched.
  - Dispatch priority: in_ex -> EXC; else op 4 -> ERTN; else op 1-3 -> ACCESS; else no-op (stays IDLE, no response, no flush).
- ACCESS, exactly 1 cycle:
  - csr_addr=num, csr_re=1.
  - csr_we=1 for op 2/3.
  - csr_wmask = rj for op 3, 32'hffffffff for op 2, 0 for op 1.
  - csr_wdata=rd.
  - csr_rdata is captured into rsp_rdata at the closing edge. This is the pre-write value.
  - Next state: RESP.
- RESP:
  - rsp_valid=1, rsp_rdata stable until rsp_ready.
  - On handshake: op 1 -> IDLE; op 2/3 -> FLUSH with flush_pc=pc+4 (mod 2^32).
- EXC, exactly 1 cycle:
  - ex_en=1; ecode/esubcode/pc/vaddr = latched values.
  - ex_entryPC is registered as flush_pc.
  - Next state: FLUSH. No CSR access, no response.
- ERTN, exactly 1 cycle:
  - ecode=ERTN_CODE, ex_en=0.
  - new_pc is registered as flush_pc.
  - Next state: FLUSH.
- FLUSH, 1 cycle: flush=1, then IDLE.
- Default outputs outside their owning state:
  - csr_addr, csr_re, csr_we, csr_wmask, csr_wdata, ex_en, ecode, esubcode, pc, vaddr, flush are all 0.
  - ecode MUST be 0 outside EXC/ERTN, because the register file acts on ertn code every cycle.
- rsp_rdata and flush_pc hold their last values outside RESP/FLUSH.
- Latency (acceptance to event):
  - csrrd: response 2 cycles after acceptance (ACCESS, then RESP).
  - csrwr/csrxchg: flush 1 cycle after the response handshake.
  - exception and ertn: flush 2 cycles after acceptance.
- Boundary conditions:
  - in_ex together with any op: the exception wins; no CSR write occurs.
  - rsp_ready held low: the unit stalls in RESP and in_ready stays 0.
  - Inputs changing after acceptance: ignored.
  - in_valid during a non-IDLE state: not accepted; the requester holds the request.
- Reset (asynchronous, rstn low):
  - state=IDLE; all outputs, rsp_rdata and flush_pc = 0.
  - in_ready=1 once rstn is high.
  - Reset mid-operation aborts the operation with no flush and no response.

Test Plan:
- csrrd num=0x30, csr_rdata=0xDEADBEEF -> ACCESS: csr_re=1, csr_we=0, addr=0x30; next cycle rsp_valid=1, rsp_rdata=0xDEADBEEF; no flush.
- csrxchg num=0x6, rj=0x0000FFFF, rd=0x12345678, pc=0x1C000100, old=0xAAAAAAAA -> csr_we=1, wmask=0x0000FFFF, wdata=0x12345678; rsp_rdata=0xAAAAAAAA; after rsp_ready, flush=1 with flush_pc=0x1C000104.
- in_ex=1, ecode=0x8, esubcode=0, pc=0x1C000200, vaddr=0x5, op=2, ex_entryPC=0x1C008000 -> ex_en=1 for one cycle with those values; csr_we never asserted; next cycle flush_pc=0x1C008000.
- ertn with new_pc=0x1C000300 -> one cycle ecode=0x3e, ex_en=0; next cycle flush=1, flush_pc=0x1C000300; ecode returns to 0.
- csrrd with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held; in_ready=0; a new in_valid is not accepted until the handshake completes.
- Assert rstn=0 during RESP of csrwr -> all outputs 0 immediately; after release in_ready=1; no flush or response emitted.
